cdb_arbiter: RTL and testbench

//  Grants the common data bus (CDB) to one functional-unit output buffer per cycle.

---
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter.sv | 125 ++++++++++++
 tb/tb_cdb_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Bus between the functional-unit output buffers and the CDB arbiter.
// master = requester side (output buffers), slave = arbiter side.
interface cdb_arbiter_if #(
    parameter int N_REQ     = 3,
    parameter int IDX_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]     request;
    logic [N_REQ-1:0]     permit;
    logic                 cdb_valid;
    logic [IDX_WIDTH-1:0] grant_index;
    logic [N_REQ-1:0]     starved;

    modport master (
        output request,
        input  permit,
        input  cdb_valid,
        input  grant_index,
        input  starved
    );

    modport slave (
        input  request,
        output permit,
        output cdb_valid,
        output grant_index,
        output starved
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: zero-latency one-hot grant with starvation forcing,
// an optional fixed-priority requester and round-robin fallback.
module cdb_arbiter #(
    parameter int N_REQ        = 3,
    parameter int PRIORITY_REQ = N_REQ - 1,
    parameter int MAX_WAIT     = 4,
    parameter int IDX_WIDTH    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic         clk,
    input  logic         reset,
    cdb_arbiter_if.slave bus
);
    localparam int                   WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam bit                   PRIO_EN  = (PRIORITY_REQ >= 0) && (PRIORITY_REQ < N_REQ);
    localparam int                   PRIO_IDX = PRIO_EN ? PRIORITY_REQ : 0;
    localparam logic [WAIT_W-1:0]    WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_REQ - 1);

    logic [IDX_WIDTH-1:0] rr_ptr_r;
    logic [WAIT_W-1:0]    wait_cnt_r [N_REQ];
    logic [N_REQ-1:0]     starved_s;
    logic [N_REQ-1:0]     starve_req_s;
    logic [N_REQ-1:0]     rot_req_s;
    logic [IDX_WIDTH-1:0] rr_off_s;
    logic                 found_s;
    logic [IDX_WIDTH-1:0] grant_idx_s;
    logic [N_REQ-1:0]     permit_s;

    // Index of the lowest set bit; 0 for an all-zero vector.
    function automatic logic [IDX_WIDTH-1:0] lowest_set(input logic [N_REQ-1:0] v);
        logic [IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_WIDTH'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Starvation flags and the request vector rotated so bit 0 sits at rr_ptr.
    always_comb begin
        starved_s = '0;
        rot_req_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            starved_s[i] = (wait_cnt_r[i] == WAIT_MAX);
            rot_req_s[i] = bus.request[IDX_WIDTH'((int'(rr_ptr_r) + i) % N_REQ)];
        end
        starve_req_s = bus.request & starved_s;
        rr_off_s     = lowest_set(rot_req_s);
    end

    // Grant selection: starvation, then fixed priority, then round-robin.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        if (|starve_req_s) begin
            found_s     = 1'b1;
            grant_idx_s = lowest_set(starve_req_s);
        end else if (PRIO_EN && bus.request[PRIO_IDX]) begin
            found_s     = 1'b1;
            grant_idx_s = IDX_WIDTH'(PRIO_IDX);
        end else if (|bus.request) begin
            found_s     = 1'b1;
            grant_idx_s = IDX_WIDTH'((int'(rr_ptr_r) + int'(rr_off_s)) % N_REQ);
        end else begin
            found_s     = 1'b0;
            grant_idx_s = '0;
        end
    end

    // One-hot decode of the selected index; never more than one bit set.
    always_comb begin
        permit_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            permit_s[i] = found_s && (grant_idx_s == IDX_WIDTH'(i));
        end
    end

    // Outputs are forced quiet while reset is held low.
    always_comb begin
        bus.permit      = '0;
        bus.cdb_valid   = 1'b0;
        bus.grant_index = '0;
        bus.starved     = '0;
        if (reset) begin
            bus.permit      = permit_s;
            bus.cdb_valid   = found_s;
            bus.grant_index = grant_idx_s;
            bus.starved     = starved_s;
        end else begin
            bus.permit      = '0;
            bus.cdb_valid   = 1'b0;
            bus.grant_index = '0;
            bus.starved     = '0;
        end
    end

    // Round-robin pointer and saturating per-requester wait counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_r <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt_r[i] <= '0;
            end
        end else begin
            if (found_s) begin
                rr_ptr_r <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + IDX_WIDTH'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (permit_s[i] || !bus.request[i]) begin
                    wait_cnt_r[i] <= '0;
                end else if (wait_cnt_r[i] != WAIT_MAX) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + WAIT_W'(1);
                end else begin
                    wait_cnt_r[i] <= wait_cnt_r[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomised checks of cdb_arbiter with N_REQ=3, PRIORITY_REQ=2, MAX_WAIT=4.
module tb_cdb_arbiter;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    cdb_arbiter_if #(.N_REQ(3), .IDX_WIDTH(2)) bus ();

    cdb_arbiter #(
        .N_REQ(3),
        .PRIORITY_REQ(2),
        .MAX_WAIT(4),
        .IDX_WIDTH(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] p, input logic v,
                             input logic [1:0] idx, input logic [2:0] st);
        check({tag, ".permit"},  32'(bus.permit),      32'(p));
        check({tag, ".valid"},   32'(bus.cdb_valid),   32'(v));
        check({tag, ".index"},   32'(bus.grant_index), 32'(idx));
        check({tag, ".starved"}, 32'(bus.starved),     32'(st));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        bus.request = 3'b000;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int          exp3_idx [11];
        logic [2:0]  exp3_st  [11];
        int          cnt_m [3];
        int          ref_m [3];
        int          rr_m;
        int          g;
        logic [2:0]  r;
        logic [2:0]  st_m;

        exp3_idx = '{2, 2, 2, 2, 0, 1, 2, 2, 2, 0, 1};
        exp3_st  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b010,
                     3'b000, 3'b000, 3'b000, 3'b001, 3'b010};
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        bus.request  = 3'b000;
        repeat (2) @(negedge clk);

        // Reset held with all requesting: everything quiet.
        bus.request = 3'b111;
        @(negedge clk);
        #1 check_out("t1_reset", 3'b000, 1'b0, 2'd0, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        #1 check_out("t1_first", 3'b100, 1'b1, 2'd2, 3'b000);

        // Two requesters alternate through round-robin.
        do_reset();
        bus.request = 3'b011;
        for (int c = 0; c < 6; c++) begin
            #1 check_out($sformatf("t2_c%0d", c), (c % 2 == 0) ? 3'b001 : 3'b010,
                         1'b1, 2'((c % 2)), 3'b000);
            @(negedge clk);
        end

        // Priority requester interrupted by starvation forcing.
        do_reset();
        bus.request = 3'b111;
        for (int c = 0; c < 11; c++) begin
            #1 check_out($sformatf("t3_c%0d", c), 3'(1 << exp3_idx[c]), 1'b1,
                         2'(exp3_idx[c]), exp3_st[c]);
            @(negedge clk);
        end

        // Idle cycles hold the round-robin pointer.
        do_reset();
        bus.request = 3'b001;
        for (int c = 0; c < 3; c++) begin
            #1 check_out($sformatf("t4_req_c%0d", c), 3'b001, 1'b1, 2'd0, 3'b000);
            @(negedge clk);
        end
        bus.request = 3'b000;
        for (int c = 0; c < 2; c++) begin
            #1 check_out($sformatf("t4_idle_c%0d", c), 3'b000, 1'b0, 2'd0, 3'b000);
            @(negedge clk);
        end
        bus.request = 3'b011;
        #1 check_out("t4_resume", 3'b010, 1'b1, 2'd1, 3'b000);

        // Dropping a request clears its wait counter.
        do_reset();
        bus.request = 3'b111;
        for (int c = 0; c < 3; c++) begin
            #1 check_out($sformatf("t5_pre_c%0d", c), 3'b100, 1'b1, 2'd2, 3'b000);
            @(negedge clk);
        end
        bus.request = 3'b110;
        #1 check_out("t5_drop", 3'b100, 1'b1, 2'd2, 3'b000);
        @(negedge clk);
        bus.request = 3'b111;
        #1 check_out("t5_post_c0", 3'b010, 1'b1, 2'd1, 3'b010);
        @(negedge clk);
        #1 check_out("t5_post_c1", 3'b100, 1'b1, 2'd2, 3'b000);
        @(negedge clk);
        #1 check_out("t5_post_c2", 3'b100, 1'b1, 2'd2, 3'b000);

        // Reset mid-stream: state and counters restart from zero.
        @(negedge clk);
        reset = 1'b0;
        #1 check_out("t6_in_reset", 3'b000, 1'b0, 2'd0, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 check_out($sformatf("t6_c%0d", c), 3'(1 << exp3_idx[c]), 1'b1,
                         2'(exp3_idx[c]), exp3_st[c]);
            @(negedge clk);
        end

        // Random requests against an independent reference model.
        do_reset();
        rr_m = 0;
        for (int i = 0; i < 3; i++) begin
            cnt_m[i] = 0;
            ref_m[i] = 0;
        end
        for (int n = 0; n < 10000; n++) begin
            r           = 3'($urandom_range(0, 7));
            bus.request = r;
            g           = -1;
            st_m        = 3'b000;
            for (int i = 0; i < 3; i++) begin
                st_m[i] = (cnt_m[i] == 4);
                if (g < 0 && r[i] && cnt_m[i] == 4) g = i;
            end
            if (g < 0 && r[2]) g = 2;
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && r[(rr_m + k) % 3]) g = (rr_m + k) % 3;
            end
            #1;
            check("rnd.permit", 32'(bus.permit), (g < 0) ? 32'd0 : (32'd1 << g));
            check("rnd.valid", 32'(bus.cdb_valid), 32'(|r));
            check("rnd.index", 32'(bus.grant_index), (g < 0) ? 32'd0 : 32'(g));
            check("rnd.starved", 32'(bus.starved), 32'(st_m));
            check("rnd.onehot0", 32'($onehot0(bus.permit)), 32'd1);
            check("rnd.permit_req", 32'(bus.permit & ~r), 32'd0);
            if (g >= 0) rr_m = (g == 2) ? 0 : g + 1;
            for (int i = 0; i < 3; i++) begin
                if (g == i || !r[i]) cnt_m[i] = 0;
                else if (cnt_m[i] < 4) cnt_m[i]++;
                if (r[i] && !bus.permit[i]) ref_m[i]++;
                else ref_m[i] = 0;
            end
            check("rnd.wait_bound", 32'((ref_m[0] <= 6) && (ref_m[1] <= 6) && (ref_m[2] <= 6)), 32'd1);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
